// File: rtl/mem_req_scheduler.sv
// mem_req_scheduler
//   Shares the single bridge read port between the ICache and DCache read
//   streams, and posts DCache writes into a WB_DEPTH-entry FIFO that drains
//   to the bridge write port one outstanding write at a time. A read whose
//   cache line (addr[31:4]) matches a buffered or in-flight write is held
//   back until that write has completed.
//   Optional feature macro: STARVE_GUARD_EN. When defined, an ICache
//   starvation counter flips read priority to the ICache after STARVE_LIMIT
//   consecutive denied cycles. When undefined, DCache always has priority.
//
// Handshake: every *_req/*_rdy pair transfers one item in a cycle where both
// are 1. Requesters keep req and payload stable until their rdy is seen;
// a read selected but not accepted is latched and shown unchanged on rd_*
// until rd_rdy. All *_req and *_rdy outputs are 0 while reset is 1.
module mem_req_scheduler #(
  parameter int WB_DEPTH     = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic         aclk,
  input  logic         reset,
  input  logic         i_ic_rd_req,
  input  logic [2:0]   i_ic_rd_type,
  input  logic [31:0]  i_ic_rd_addr,
  output logic         o_ic_rd_rdy,
  input  logic         i_dc_rd_req,
  input  logic [2:0]   i_dc_rd_type,
  input  logic [31:0]  i_dc_rd_addr,
  output logic         o_dc_rd_rdy,
  input  logic         i_dc_wr_req,
  input  logic [2:0]   i_dc_wr_type,
  input  logic [31:0]  i_dc_wr_addr,
  input  logic [3:0]   i_dc_wr_wstrb,
  input  logic [127:0] i_dc_wr_data,
  output logic         o_dc_wr_rdy,
  output logic         o_rd_req,
  output logic [2:0]   o_rd_type,
  output logic [31:0]  o_rd_addr,
  output logic         o_rd_id,
  input  logic         i_rd_rdy,
  output logic         o_wr_req,
  output logic [2:0]   o_wr_type,
  output logic [31:0]  o_wr_addr,
  output logic [3:0]   o_wr_wstrb,
  output logic [127:0] o_wr_data,
  input  logic         i_wr_rdy,
  input  logic         i_wr_done,
  output logic         o_rd_state
);

  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  if ((WB_DEPTH < 2) || ((WB_DEPTH & (WB_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("WB_DEPTH must be a power of two and at least 2");
  end
  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..255");
  end

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} rd_state_t;

  logic [2:0]    r_wb_type  [WB_DEPTH];
  logic [31:0]   r_wb_addr  [WB_DEPTH];
  logic [3:0]    r_wb_wstrb [WB_DEPTH];
  logic [127:0]  r_wb_data  [WB_DEPTH];
  logic [WB_DEPTH-1:0] r_wb_vld;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_wr_busy;
  logic [27:0]   r_busy_line;

  rd_state_t     r_state;
  logic          r_hold_id;
  logic [2:0]    r_hold_type;
  logic [31:0]   r_hold_addr;

  logic w_full, w_empty, w_push, w_pop;
  logic w_ic_hazard, w_dc_hazard, w_ic_elig, w_dc_elig, w_pick_ic, w_prio;

  assign w_full      = (r_count == CW'(WB_DEPTH));
  assign w_empty     = (r_count == '0);
  assign o_dc_wr_rdy = ~w_full & ~reset;
  assign w_push      = i_dc_wr_req & o_dc_wr_rdy;
  assign o_wr_req    = ~w_empty & ~r_wr_busy & ~reset;
  assign w_pop       = o_wr_req & i_wr_rdy;
  assign o_wr_type   = r_wb_type[r_rd_ptr];
  assign o_wr_addr   = r_wb_addr[r_rd_ptr];
  assign o_wr_wstrb  = r_wb_wstrb[r_rd_ptr];
  assign o_wr_data   = r_wb_data[r_rd_ptr];
  assign o_rd_state  = (r_state == S_HOLD);

  // Write buffer payload storage; validity is tracked separately so no reset is needed.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_wb_type[r_wr_ptr]  <= i_dc_wr_type;
      r_wb_addr[r_wr_ptr]  <= i_dc_wr_addr;
      r_wb_wstrb[r_wr_ptr] <= i_dc_wr_wstrb;
      r_wb_data[r_wr_ptr]  <= i_dc_wr_data;
    end
  end

  // Write buffer pointers, occupancy and per-entry valid flags.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wb_vld <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr           <= r_wr_ptr + PW'(1);
        r_wb_vld[r_wr_ptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr           <= r_rd_ptr + PW'(1);
        r_wb_vld[r_rd_ptr] <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Single outstanding bridge write: busy from issue until the B pulse.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_wr_busy   <= 1'b0;
      r_busy_line <= '0;
    end else if (w_pop) begin
      r_wr_busy   <= 1'b1;
      r_busy_line <= o_wr_addr[31:4];
    end else if (i_wr_done) begin
      r_wr_busy   <= 1'b0;
    end
  end

  // Line-overlap hazard of each read against buffered and in-flight writes.
  always_comb begin
    w_ic_hazard = r_wr_busy & (r_busy_line == i_ic_rd_addr[31:4]);
    w_dc_hazard = r_wr_busy & (r_busy_line == i_dc_rd_addr[31:4]);
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (r_wb_vld[i] && (r_wb_addr[i][31:4] == i_ic_rd_addr[31:4])) w_ic_hazard = 1'b1;
      if (r_wb_vld[i] && (r_wb_addr[i][31:4] == i_dc_rd_addr[31:4])) w_dc_hazard = 1'b1;
    end
  end

  assign w_ic_elig = i_ic_rd_req & ~w_ic_hazard;
  assign w_dc_elig = i_dc_rd_req & ~w_dc_hazard;
  assign w_pick_ic = w_ic_elig & (~w_dc_elig | w_prio);

  // Bridge read request: live winner in IDLE, latched selection in HOLD.
  always_comb begin
    o_rd_req  = 1'b0;
    o_rd_id   = 1'b0;
    o_rd_type = '0;
    o_rd_addr = '0;
    if (!reset) begin
      if (r_state == S_HOLD) begin
        o_rd_req  = 1'b1;
        o_rd_id   = r_hold_id;
        o_rd_type = r_hold_type;
        o_rd_addr = r_hold_addr;
      end else if (w_ic_elig || w_dc_elig) begin
        o_rd_req  = 1'b1;
        o_rd_id   = ~w_pick_ic;
        o_rd_type = w_pick_ic ? i_ic_rd_type : i_dc_rd_type;
        o_rd_addr = w_pick_ic ? i_ic_rd_addr : i_dc_rd_addr;
      end
    end
  end

  assign o_ic_rd_rdy = i_rd_rdy & o_rd_req & ~o_rd_id;
  assign o_dc_rd_rdy = i_rd_rdy & o_rd_req & o_rd_id;

  // Read arbitration FSM: latch an unaccepted selection and hold it until rd_rdy.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_hold_id   <= 1'b0;
      r_hold_type <= '0;
      r_hold_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (o_rd_req && !i_rd_rdy) begin
            r_state     <= S_HOLD;
            r_hold_id   <= o_rd_id;
            r_hold_type <= o_rd_type;
            r_hold_addr <= o_rd_addr;
          end
        end
        S_HOLD: begin
          if (i_rd_rdy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef STARVE_GUARD_EN
  logic [7:0] r_starve_cnt;
  logic       r_prio;
  logic       w_at_limit;

  // Reaching the limit gives ICache priority in that same cycle; r_prio keeps it until served.
  assign w_at_limit = (r_starve_cnt == 8'(STARVE_LIMIT));
  assign w_prio     = r_prio | w_at_limit;

  // Count consecutive denied ICache cycles; flip priority at the limit.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_prio       <= 1'b0;
    end else begin
      if (!i_ic_rd_req || o_ic_rd_rdy) r_starve_cnt <= '0;
      else if (!w_at_limit)            r_starve_cnt <= r_starve_cnt + 8'd1;
      if (o_ic_rd_rdy)     r_prio <= 1'b0;
      else if (w_at_limit) r_prio <= 1'b1;
    end
  end
`else
  assign w_prio = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_scheduler.sv
// tb_mem_req_scheduler
//   Directed scenarios for reset, arbitration, hold, write buffering, line
//   hazards and starvation, then a randomized run checked against a
//   queue-based reference model. Build with or without STARVE_GUARD_EN.
module tb_mem_req_scheduler;
  localparam int WB_DEPTH     = 2;
  localparam int STARVE_LIMIT = 8;

  logic         aclk = 1'b0;
  logic         reset;
  logic         ic_rd_req, dc_rd_req, dc_wr_req;
  logic [2:0]   ic_rd_type, dc_rd_type, dc_wr_type;
  logic [31:0]  ic_rd_addr, dc_rd_addr, dc_wr_addr;
  logic [3:0]   dc_wr_wstrb;
  logic [127:0] dc_wr_data;
  logic         ic_rd_rdy, dc_rd_rdy, dc_wr_rdy;
  logic         rd_req, rd_id, rd_rdy;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         wr_req, wr_rdy, wr_done;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         rd_state;

  // Scoreboard of accepted-but-not-issued writes: {type, addr, wstrb, data}.
  logic [166:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model state for the randomized run.
  logic        m_busy;
  logic [27:0] m_busy_line;
  logic        m_commit;
  logic        m_cid;
  logic [2:0]  m_ctype;
  logic [31:0] m_caddr;
  int          m_starve;
  logic        m_prio;
  logic [31:0] bases [4];

  mem_req_scheduler #(.WB_DEPTH(WB_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .aclk(aclk), .reset(reset),
    .i_ic_rd_req(ic_rd_req), .i_ic_rd_type(ic_rd_type), .i_ic_rd_addr(ic_rd_addr), .o_ic_rd_rdy(ic_rd_rdy),
    .i_dc_rd_req(dc_rd_req), .i_dc_rd_type(dc_rd_type), .i_dc_rd_addr(dc_rd_addr), .o_dc_rd_rdy(dc_rd_rdy),
    .i_dc_wr_req(dc_wr_req), .i_dc_wr_type(dc_wr_type), .i_dc_wr_addr(dc_wr_addr),
    .i_dc_wr_wstrb(dc_wr_wstrb), .i_dc_wr_data(dc_wr_data), .o_dc_wr_rdy(dc_wr_rdy),
    .o_rd_req(rd_req), .o_rd_type(rd_type), .o_rd_addr(rd_addr), .o_rd_id(rd_id), .i_rd_rdy(rd_rdy),
    .o_wr_req(wr_req), .o_wr_type(wr_type), .o_wr_addr(wr_addr), .o_wr_wstrb(wr_wstrb),
    .o_wr_data(wr_data), .i_wr_rdy(wr_rdy), .i_wr_done(wr_done),
    .o_rd_state(rd_state)
  );

  // Clock and watchdog.
  always #5 aclk = ~aclk;
  initial begin
    #400000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_rd_req = 1'b0; ic_rd_type = '0; ic_rd_addr = '0;
    dc_rd_req = 1'b0; dc_rd_type = '0; dc_rd_addr = '0;
    dc_wr_req = 1'b0; dc_wr_type = '0; dc_wr_addr = '0; dc_wr_wstrb = '0; dc_wr_data = '0;
    rd_rdy = 1'b0; wr_rdy = 1'b0; wr_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
    m_busy = 1'b0; m_busy_line = '0; m_commit = 1'b0; m_cid = 1'b0;
    m_ctype = '0; m_caddr = '0; m_starve = 0; m_prio = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    return bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 15));
  endfunction

  function automatic logic line_hit(logic [31:0] a);
    logic h;
    h = m_busy && (m_busy_line == a[31:4]);
    foreach (exp_q[i]) if (exp_q[i][163:136] == a[31:4]) h = 1'b1;
    return h;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_3000; dc_rd_req = 1'b1; dc_rd_addr = 32'h0000_4000;
    dc_wr_req = 1'b1; dc_wr_addr = 32'h0000_5000; rd_rdy = 1'b1; wr_rdy = 1'b1;
    step(); step();
    @(negedge aclk);
    n_vec++;
    if ({rd_req, wr_req, ic_rd_rdy, dc_rd_rdy, dc_wr_rdy} !== 5'b0) begin
      n_err++; $display("FAIL reset_outputs got %b exp 00000", {rd_req, wr_req, ic_rd_rdy, dc_rd_rdy, dc_wr_rdy});
    end
    step();
    reset = 1'b0;
    idle_inputs();
    @(negedge aclk);
    n_vec++;
    if ({rd_req, wr_req, dc_wr_rdy} !== 3'b001) begin
      n_err++; $display("FAIL post_reset got %b exp 001", {rd_req, wr_req, dc_wr_rdy});
    end
    step();
    ic_rd_req = 1'b1; ic_rd_type = 3'd2; ic_rd_addr = 32'h1C00_0000; rd_rdy = 1'b1;
    @(negedge aclk);
    n_vec++;
    if ({rd_req, rd_id, ic_rd_rdy, dc_rd_rdy} !== 4'b1010 || rd_addr !== 32'h1C00_0000 || rd_type !== 3'd2) begin
      n_err++; $display("FAIL first_ic_read got req/id/ic/dc=%b addr=%h exp 1010 1c000000",
                        {rd_req, rd_id, ic_rd_rdy, dc_rd_rdy}, rd_addr);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_both_reads();
    ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_3000; dc_rd_req = 1'b1; dc_rd_addr = 32'h0000_4000; rd_rdy = 1'b1;
    @(negedge aclk);
    n_vec++;
    if ({rd_id, ic_rd_rdy, dc_rd_rdy} !== 3'b101 || rd_addr !== 32'h0000_4000) begin
      n_err++; $display("FAIL both_first got id/ic/dc=%b addr=%h exp 101 4000", {rd_id, ic_rd_rdy, dc_rd_rdy}, rd_addr);
    end
    step();
    dc_rd_req = 1'b0;
    @(negedge aclk);
    n_vec++;
    if ({rd_id, ic_rd_rdy, dc_rd_rdy} !== 3'b010 || rd_addr !== 32'h0000_3000) begin
      n_err++; $display("FAIL both_second got id/ic/dc=%b addr=%h exp 010 3000", {rd_id, ic_rd_rdy, dc_rd_rdy}, rd_addr);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_hold();
    ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_5000;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin dc_rd_req = 1'b1; dc_rd_addr = 32'h0000_6000; end
      @(negedge aclk);
      n_vec++;
      if ({rd_req, rd_id, ic_rd_rdy, dc_rd_rdy} !== 4'b1000 || rd_addr !== 32'h0000_5000) begin
        n_err++; $display("FAIL hold_cycle%0d got req/id/ic/dc=%b addr=%h exp 1000 5000", k,
                          {rd_req, rd_id, ic_rd_rdy, dc_rd_rdy}, rd_addr);
      end
      step();
    end
    rd_rdy = 1'b1;
    @(negedge aclk);
    n_vec++;
    if ({ic_rd_rdy, dc_rd_rdy} !== 2'b10 || rd_addr !== 32'h0000_5000) begin
      n_err++; $display("FAIL hold_release got ic/dc=%b addr=%h exp 10 5000", {ic_rd_rdy, dc_rd_rdy}, rd_addr);
    end
    step();
    ic_rd_req = 1'b0;
    @(negedge aclk);
    n_vec++;
    if ({rd_id, dc_rd_rdy} !== 2'b11 || rd_addr !== 32'h0000_6000) begin
      n_err++; $display("FAIL hold_after got id/dc=%b addr=%h exp 11 6000", {rd_id, dc_rd_rdy}, rd_addr);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_write_buffer();
    logic [127:0] d1, d2;
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    dc_wr_req = 1'b1; dc_wr_addr = 32'h0000_0100; dc_wr_data = d1; dc_wr_wstrb = 4'hF; dc_wr_type = 3'd1;
    @(negedge aclk);
    n_vec++;
    if ({dc_wr_rdy, wr_req} !== 2'b10) begin
      n_err++; $display("FAIL wb_no_bypass got rdy/wreq=%b exp 10", {dc_wr_rdy, wr_req});
    end
    step();
    dc_wr_addr = 32'h0000_0200; dc_wr_data = d2;
    step();
    dc_wr_addr = 32'h0000_0300;
    @(negedge aclk);
    n_vec++;
    if ({dc_wr_rdy, wr_req} !== 2'b01 || wr_addr !== 32'h0000_0100 || wr_data !== d1) begin
      n_err++; $display("FAIL wb_full got rdy/wreq=%b addr=%h exp 01 100", {dc_wr_rdy, wr_req}, wr_addr);
    end
    step();
    dc_wr_req = 1'b0; wr_rdy = 1'b1;
    @(negedge aclk);
    n_vec++;
    if (wr_req !== 1'b1 || wr_addr !== 32'h0000_0100 || wr_data !== d1 || wr_wstrb !== 4'hF || wr_type !== 3'd1) begin
      n_err++; $display("FAIL wb_issue1 got req=%b addr=%h exp 1 100", wr_req, wr_addr);
    end
    step();
    for (int k = 0; k < 3; k++) begin
      wr_done = (k == 2);
      @(negedge aclk);
      n_vec++;
      if (wr_req !== 1'b0) begin
        n_err++; $display("FAIL wb_one_outstanding%0d got %b exp 0", k, wr_req);
      end
      step();
    end
    wr_done = 1'b0;
    @(negedge aclk);
    n_vec++;
    if (wr_req !== 1'b1 || wr_addr !== 32'h0000_0200 || wr_data !== d2 || dc_wr_rdy !== 1'b1) begin
      n_err++; $display("FAIL wb_issue2 got req=%b addr=%h exp 1 200", wr_req, wr_addr);
    end
    step();
    wr_rdy = 1'b0; wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    @(negedge aclk);
    n_vec++;
    if ({wr_req, dc_wr_rdy} !== 2'b01) begin
      n_err++; $display("FAIL wb_drained got wreq/rdy=%b exp 01", {wr_req, dc_wr_rdy});
    end
    step();
    idle_inputs();
  endtask

  task automatic test_hazard();
    dc_wr_req = 1'b1; dc_wr_addr = 32'h0000_1004;
    step();
    dc_wr_req = 1'b0;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h0000_1008; ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_2000; rd_rdy = 1'b1;
    @(negedge aclk);
    n_vec++;
    if ({rd_id, ic_rd_rdy, dc_rd_rdy} !== 3'b010 || rd_addr !== 32'h0000_2000) begin
      n_err++; $display("FAIL hazard_ic_pass got id/ic/dc=%b addr=%h exp 010 2000", {rd_id, ic_rd_rdy, dc_rd_rdy}, rd_addr);
    end
    step();
    ic_rd_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wr_rdy = (k == 1);
      wr_done = (k == 3);
      @(negedge aclk);
      n_vec++;
      if ({rd_req, dc_rd_rdy} !== 2'b00) begin
        n_err++; $display("FAIL hazard_block%0d got req/dc=%b exp 00", k, {rd_req, dc_rd_rdy});
      end
      step();
    end
    wr_rdy = 1'b0; wr_done = 1'b0;
    @(negedge aclk);
    n_vec++;
    if (dc_rd_rdy !== 1'b1 || rd_addr !== 32'h0000_1008) begin
      n_err++; $display("FAIL hazard_release got dc=%b addr=%h exp 1 1008", dc_rd_rdy, rd_addr);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_lock_order();
    dc_rd_req = 1'b1; dc_rd_addr = 32'h0000_8000;
    step();
    dc_wr_req = 1'b1; dc_wr_addr = 32'h0000_8004;
    step();
    dc_wr_req = 1'b0;
    @(negedge aclk);
    n_vec++;
    if ({rd_req, rd_id, dc_rd_rdy, rd_state} !== 4'b1101) begin
      n_err++; $display("FAIL lock_hold got req/id/dc/state=%b exp 1101", {rd_req, rd_id, dc_rd_rdy, rd_state});
    end
    step();
    rd_rdy = 1'b1;
    @(negedge aclk);
    n_vec++;
    if (dc_rd_rdy !== 1'b1 || rd_addr !== 32'h0000_8000) begin
      n_err++; $display("FAIL lock_grant got dc=%b addr=%h exp 1 8000", dc_rd_rdy, rd_addr);
    end
    step();
    dc_wr_req = 1'b1; dc_wr_addr = 32'h0000_7000; dc_rd_addr = 32'h0000_7008;
    @(negedge aclk);
    n_vec++;
    if (dc_rd_rdy !== 1'b1 || rd_addr !== 32'h0000_7008) begin
      n_err++; $display("FAIL same_cycle_push got dc=%b addr=%h exp 1 7008", dc_rd_rdy, rd_addr);
    end
    step();
    idle_inputs();
    wr_rdy = 1'b1;
    @(negedge aclk);
    n_vec++;
    if (wr_req !== 1'b1 || wr_addr !== 32'h0000_8004) begin
      n_err++; $display("FAIL lock_drain1 got req=%b addr=%h exp 1 8004", wr_req, wr_addr);
    end
    step();
    wr_rdy = 1'b0; wr_done = 1'b1;
    step();
    wr_done = 1'b0; wr_rdy = 1'b1;
    @(negedge aclk);
    n_vec++;
    if (wr_req !== 1'b1 || wr_addr !== 32'h0000_7000) begin
      n_err++; $display("FAIL lock_drain2 got req=%b addr=%h exp 1 7000", wr_req, wr_addr);
    end
    step();
    wr_rdy = 1'b0; wr_done = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_starve();
    int got, dc_grants, exp_got, exp_dc;
    got = 0; dc_grants = 0;
`ifdef STARVE_GUARD_EN
    exp_got = STARVE_LIMIT + 1; exp_dc = STARVE_LIMIT;
`else
    exp_got = 0; exp_dc = 20;
`endif
    ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_9000; dc_rd_req = 1'b1; rd_rdy = 1'b1;
    for (int k = 1; k <= 20 && got == 0; k++) begin
      dc_rd_addr = 32'h0000_A000 + 32'(k << 4);
      @(negedge aclk);
      if (ic_rd_rdy === 1'b1) got = k;
      else if (dc_rd_rdy === 1'b1) dc_grants++;
      step();
    end
    n_vec++;
    if (got != exp_got) begin
      n_err++; $display("FAIL starve_ic_grant got %0d exp %0d", got, exp_got);
    end
    n_vec++;
    if (dc_grants != exp_dc) begin
      n_err++; $display("FAIL starve_dc_grants got %0d exp %0d", dc_grants, exp_dc);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_random();
    logic ic_ok, dc_ok, eff_prio, e_rd_req, e_id, e_ic, e_dc, e_wrdy, e_wreq;
    logic [2:0]  e_type;
    logic [31:0] e_addr;
    int old_starve;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!(m_commit && !m_cid)) begin
        ic_rd_req = 1'($urandom_range(0, 1)); ic_rd_type = 3'($urandom_range(0, 7)); ic_rd_addr = pick_addr();
      end
      if (!(m_commit && m_cid)) begin
        dc_rd_req = 1'($urandom_range(0, 1)); dc_rd_type = 3'($urandom_range(0, 7)); dc_rd_addr = pick_addr();
      end
      dc_wr_req = ($urandom_range(0, 2) == 0); dc_wr_type = 3'($urandom_range(0, 7));
      dc_wr_addr = pick_addr(); dc_wr_wstrb = 4'($urandom_range(0, 15));
      dc_wr_data = {$urandom, $urandom, $urandom, $urandom};
      rd_rdy = ($urandom_range(0, 9) < 6);
      wr_rdy = 1'($urandom_range(0, 1));
      wr_done = m_busy && ($urandom_range(0, 3) == 0);
      @(negedge aclk);
`ifdef STARVE_GUARD_EN
      eff_prio = m_prio || (m_starve >= STARVE_LIMIT);
`else
      eff_prio = 1'b0;
`endif
      e_wrdy = (exp_q.size() < WB_DEPTH);
      e_wreq = (exp_q.size() > 0) && !m_busy;
      if (m_commit) begin
        e_rd_req = 1'b1; e_id = m_cid; e_type = m_ctype; e_addr = m_caddr;
      end else begin
        ic_ok = ic_rd_req && !line_hit(ic_rd_addr);
        dc_ok = dc_rd_req && !line_hit(dc_rd_addr);
        e_rd_req = ic_ok || dc_ok;
        e_id = !(ic_ok && (!dc_ok || eff_prio));
        e_type = e_id ? dc_rd_type : ic_rd_type;
        e_addr = e_id ? dc_rd_addr : ic_rd_addr;
      end
      e_ic = rd_rdy && e_rd_req && !e_id;
      e_dc = rd_rdy && e_rd_req && e_id;
      n_vec++;
      if ({rd_req, ic_rd_rdy, dc_rd_rdy, dc_wr_rdy, wr_req} !== {e_rd_req, e_ic, e_dc, e_wrdy, e_wreq}) begin
        n_err++; $display("FAIL rand_ctl cyc=%0d got %b exp %b", c,
                          {rd_req, ic_rd_rdy, dc_rd_rdy, dc_wr_rdy, wr_req}, {e_rd_req, e_ic, e_dc, e_wrdy, e_wreq});
      end
      if (e_rd_req) begin
        n_vec++;
        if ({rd_id, rd_type, rd_addr} !== {e_id, e_type, e_addr}) begin
          n_err++; $display("FAIL rand_rd cyc=%0d got id=%b addr=%h exp id=%b addr=%h", c, rd_id, rd_addr, e_id, e_addr);
        end
      end
      if (e_wreq) begin
        n_vec++;
        if ({wr_type, wr_addr, wr_wstrb, wr_data} !== exp_q[0]) begin
          n_err++; $display("FAIL rand_wr cyc=%0d got addr=%h exp addr=%h", c, wr_addr, exp_q[0][163:132]);
        end
      end
      if (e_wreq && wr_rdy) begin
        m_busy = 1'b1; m_busy_line = exp_q[0][163:136];
        void'(exp_q.pop_front());
      end else if (wr_done) begin
        m_busy = 1'b0;
      end
      if (dc_wr_req && e_wrdy) exp_q.push_back({dc_wr_type, dc_wr_addr, dc_wr_wstrb, dc_wr_data});
      if (m_commit) begin
        if (rd_rdy) m_commit = 1'b0;
      end else if (e_rd_req && !rd_rdy) begin
        m_commit = 1'b1; m_cid = e_id; m_ctype = e_type; m_caddr = e_addr;
      end
      old_starve = m_starve;
      if (!ic_rd_req || e_ic) m_starve = 0;
      else if (m_starve < STARVE_LIMIT) m_starve++;
      if (e_ic) m_prio = 1'b0;
      else if (old_starve >= STARVE_LIMIT) m_prio = 1'b1;
      step();
    end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    do_reset();
    dc_wr_req = 1'b1; dc_wr_addr = 32'h0000_A000;
    step();
    dc_wr_addr = 32'h0000_B000;
    step();
    dc_wr_req = 1'b0;
    @(negedge aclk);
    n_vec++;
    if ({wr_req, dc_wr_rdy} !== 2'b10) begin
      n_err++; $display("FAIL midrst_before got wreq/rdy=%b exp 10", {wr_req, dc_wr_rdy});
    end
    step();
    reset = 1'b1; wr_rdy = 1'b1; dc_rd_req = 1'b1; dc_rd_addr = 32'h0000_C000; rd_rdy = 1'b1;
    @(negedge aclk);
    n_vec++;
    if ({rd_req, wr_req, ic_rd_rdy, dc_rd_rdy, dc_wr_rdy} !== 5'b0) begin
      n_err++; $display("FAIL midrst_during got %b exp 00000", {rd_req, wr_req, ic_rd_rdy, dc_rd_rdy, dc_wr_rdy});
    end
    step();
    reset = 1'b0;
    idle_inputs();
    @(negedge aclk);
    n_vec++;
    if ({rd_req, wr_req, dc_wr_rdy} !== 3'b001) begin
      n_err++; $display("FAIL midrst_after got %b exp 001", {rd_req, wr_req, dc_wr_rdy});
    end
    step();
  endtask

  initial begin
    bases[0] = 32'h0000_1000; bases[1] = 32'h0000_1010;
    bases[2] = 32'h0000_2000; bases[3] = 32'h0000_2010;
    idle_inputs();
    test_reset();
    test_both_reads();
    test_hold();
    test_write_buffer();
    test_hazard();
    test_lock_order();
    test_starve();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
